// File: rtl/vga_pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and its PLL / VGA-domain neighbours.
interface vga_pll_reset_sequencer_if;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [3:0] retries;
    logic [7:0] lol_count;

    modport slave (
        input  pll_locked, relock_req,
        output pll_rst, sys_rst, ready, fail, retries, lol_count
    );

    modport master (
        output pll_locked, relock_req,
        input  pll_rst, sys_rst, ready, fail, retries, lol_count
    );
endinterface

// File: rtl/vga_pll_reset_sequencer.sv
// PLL reset/lock sequencer on the reference clock; releases the VGA-domain reset only on a qualified lock.
// Define PLLSEQ_LOL_COUNT_EN to build the saturating loss-of-lock counter (lol_count reads 0 otherwise).
module vga_pll_reset_sequencer #(
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_TIMEOUT   = 50000,
    parameter int LOCK_STABLE    = 256,
    parameter int RELEASE_CYCLES = 8,
    parameter int MAX_RETRIES    = 3
) (
    input logic                      refclk,
    input logic                      rst,
    vga_pll_reset_sequencer_if.slave bus
);
    localparam int MAX_AB  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CD  = (LOCK_STABLE > RELEASE_CYCLES) ? LOCK_STABLE : RELEASE_CYCLES;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(RELEASE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       retries_q, retries_d;
    logic             pll_rst_q, pll_rst_d;
    logic             sys_rst_q, sys_rst_d;
    logic             ready_q, ready_d;
    logic             fail_q, fail_d;
    logic             cnt_clr;
    logic             sync_q, locked_s_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_q     <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync_q     <= bus.pll_locked;
            locked_s_q <= sync_q;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RESET_PLL;
            cnt_q     <= '0;
            retries_q <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            pll_rst_q <= pll_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        cnt_clr   = 1'b0;
        cnt_d     = cnt_q;

        unique case (state_q)
            S_RESET_PLL: if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (locked_s_q) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    if (retries_q == RETRY_LIMIT) begin
                        state_d = S_FAIL;
                    end else begin
                        retries_d = retries_q + 4'd1;
                        state_d   = S_RESET_PLL;
                    end
                end
            end
            S_STABLE: begin
                if (!locked_s_q)                state_d = S_WAIT_LOCK;
                else if (cnt_q == STABLE_LAST)  state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!locked_s_q)                state_d = S_WAIT_LOCK;
                else if (cnt_q == RELEASE_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (!locked_s_q) begin
                    retries_d = '0;
                    state_d   = S_RESET_PLL;
                end
            end
            S_FAIL:  state_d = S_FAIL;
            default: state_d = S_RESET_PLL;
        endcase

        // A relock request overrides everything and restarts the pulse even from RESET_PLL.
        if (bus.relock_req) begin
            state_d   = S_RESET_PLL;
            retries_d = '0;
            cnt_clr   = 1'b1;
        end

        if (cnt_clr || (state_d != state_q)) cnt_d = '0;
        else if (state_q != S_RUN && state_q != S_FAIL) cnt_d = cnt_q + CNT_W'(1);

        // Outputs are decoded from the next state so they are registered yet change with the state.
        pll_rst_d = (state_d == S_RESET_PLL) || (state_d == S_FAIL);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

`ifdef PLLSEQ_LOL_COUNT_EN
    logic [7:0] lol_count_q, lol_count_d;
    logic       lol_event;

    assign lol_event = (state_q == S_RUN) && !locked_s_q;

    always_comb begin
        lol_count_d = lol_count_q;
        if (lol_event && (lol_count_q != 8'hFF)) lol_count_d = lol_count_q + 8'd1;
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) lol_count_q <= '0;
        else     lol_count_q <= lol_count_d;
    end

    assign bus.lol_count = lol_count_q;
`else
    assign bus.lol_count = 8'd0;
`endif

    assign bus.pll_rst = pll_rst_q;
    assign bus.sys_rst = sys_rst_q;
    assign bus.ready   = ready_q;
    assign bus.fail    = fail_q;
    assign bus.retries = retries_q;
endmodule

// File: tb/tb_vga_pll_reset_sequencer.sv
// Scoreboard bench: stimulus queues (cycle, output vector) expectations; a monitor pops one per output change.
module tb_vga_pll_reset_sequencer;
    localparam int HALF = 10;

    typedef struct {
        int          cyc;
        logic [15:0] v;
    } exp_t;

    logic refclk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   total  = 0;
    int   passed = 0;
    int   lol_m  = 0;
    exp_t q[$];

    vga_pll_reset_sequencer_if bus();

    vga_pll_reset_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .LOCK_STABLE   (5),
        .RELEASE_CYCLES(3),
        .MAX_RETRIES   (2)
    ) dut (
        .refclk(refclk),
        .rst   (rst),
        .bus   (bus)
    );

    always #HALF refclk = ~refclk;
    always @(posedge refclk) cyc <= cyc + 1;

    // Output vector layout: {pll_rst, sys_rst, ready, fail, retries[3:0], lol_count[7:0]}.
    function automatic logic [15:0] vec(input bit pr, input bit sr, input bit rd, input bit fl,
                                        input int rt, input int lc);
        return {pr, sr, rd, fl, 4'(rt), 8'(lc)};
    endfunction

    function automatic logic [15:0] sample();
        return {bus.pll_rst, bus.sys_rst, bus.ready, bus.fail, bus.retries, bus.lol_count};
    endfunction

    task automatic check(input string name, input int act_c, input logic [15:0] act_v,
                         input int exp_c, input logic [15:0] exp_v);
        total++;
        if (act_c == exp_c && act_v === exp_v) passed++;
        else $display("FAIL %s: got cyc=%0d out=%h, want cyc=%0d out=%h",
                      name, act_c, act_v, exp_c, exp_v);
    endtask

    task automatic push(input int c, input logic [15:0] v);
        q.push_back('{c, v});
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge refclk);
    endtask

    task automatic lol_event();
`ifdef PLLSEQ_LOL_COUNT_EN
        if (lol_m < 255) lol_m++;
`endif
    endtask

    // Called on the negedge whose cyc equals the edge where RESET_PLL's counter sat at 0.
    task automatic bring_up(input int start, input int k, input bit glitch, input bit to_run);
        int s;
        s = start;
        for (int i = 0; i < k; i++) begin
            push(s + 4,  vec(0, 1, 0, 0, i, lol_m));
            push(s + 24, vec(1, 1, 0, 0, i + 1, lol_m));
            s += 24;
        end
        push(s + 4, vec(0, 1, 0, 0, k, lol_m));
        wait_to(s + 6);
        bus.pll_locked = 1'b1;
        if (glitch) begin
            wait_to(s + 10);
            bus.pll_locked = 1'b0;
            wait_to(s + 11);
            bus.pll_locked = 1'b1;
        end
        if (to_run) begin
            push(s + (glitch ? 22 : 17), vec(0, 0, 1, 0, k, lol_m));
            wait_to(s + (glitch ? 22 : 17));
        end
    endtask

    initial begin : monitor
        logic [15:0] prev, cur;
        exp_t        e;
        prev = vec(1, 1, 0, 0, 0, 0);
        forever begin
            @(negedge refclk);
            cur = sample();
            if (cur !== prev) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_change: got cyc=%0d out=%h, want no change from %h",
                             cyc, cur, prev);
                end else begin
                    e = q.pop_front();
                    check("output_change", cyc, cur, e.cyc, e.v);
                end
                prev = cur;
            end
        end
    end

    initial begin : watchdog
        #(2 * HALF * 20000);
        $display("FAIL watchdog: got cyc=%0d, want completion before 20000 cycles", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int   c, s;
        exp_t e;
        rst            = 1'b0;
        bus.pll_locked = 1'b0;
        bus.relock_req = 1'b0;
        #1 rst = 1'b1;

        // Reset state, then bring-up with lock arriving two cycles after pll_rst falls.
        @(negedge refclk);
        check("reset_state", cyc, sample(), 1, vec(1, 1, 0, 0, 0, 0));
        wait_to(3);
        rst = 1'b0;
        bring_up(3, 0, 0, 1);

        // Loss of lock in RUN, lock stays away: three pulses, retries 1 then 2, then sticky FAIL.
        c = cyc;
        bus.pll_locked = 1'b0;
        lol_event();
        push(c + 3, vec(1, 1, 0, 0, 0, lol_m));
        s = c + 3;
        for (int i = 0; i < 3; i++) begin
            push(s + 4 + 24 * i, vec(0, 1, 0, 0, i, lol_m));
            push(s + 24 + 24 * i, (i < 2) ? vec(1, 1, 0, 0, i + 1, lol_m) : vec(1, 1, 0, 1, 2, lol_m));
        end
        wait_to(s + 80);
        bus.pll_locked = 1'b1;
        wait_to(s + 95);
        bus.pll_locked = 1'b0;
        wait_to(s + 100);
        push(s + 101, vec(1, 1, 0, 0, 0, lol_m));
        bus.relock_req = 1'b1;
        wait_to(s + 101);
        bus.relock_req = 1'b0;
        bring_up(s + 101, 0, 0, 1);

        // One timeout, then a one-cycle glitch after 3 good STABLE cycles; retries stays 1.
        c = cyc;
        push(c + 1, vec(1, 1, 0, 0, 0, lol_m));
        bus.relock_req = 1'b1;
        bus.pll_locked = 1'b0;
        wait_to(c + 1);
        bus.relock_req = 1'b0;
        bring_up(c + 1, 1, 1, 1);

        // Relock request on the same edge as a loss of lock: both take effect.
        c = cyc;
        bus.pll_locked = 1'b0;
        lol_event();
        push(c + 3, vec(1, 1, 0, 0, 0, lol_m));
        wait_to(c + 2);
        bus.relock_req = 1'b1;
        wait_to(c + 3);
        bus.relock_req = 1'b0;
        bring_up(c + 3, 0, 0, 1);

        // Repeated loss of lock drives lol_count into saturation.
        for (int n = 0; n < 300; n++) begin
            c = cyc;
            bus.pll_locked = 1'b0;
            lol_event();
            push(c + 3, vec(1, 1, 0, 0, 0, lol_m));
            wait_to(c + 3);
            bring_up(c + 3, 0, 0, 1);
        end
`ifdef PLLSEQ_LOL_COUNT_EN
        check("lol_saturated", cyc, {8'd0, bus.lol_count}, cyc, 16'd255);
`else
        check("lol_tied_off", cyc, {8'd0, bus.lol_count}, cyc, 16'd0);
`endif

        // Relock in RUN, with a second request inside RESET_PLL restarting the pulse.
        c = cyc;
        push(c + 1, vec(1, 1, 0, 0, 0, lol_m));
        bus.relock_req = 1'b1;
        bus.pll_locked = 1'b0;
        wait_to(c + 1);
        bus.relock_req = 1'b0;
        wait_to(c + 3);
        bus.relock_req = 1'b1;
        wait_to(c + 4);
        bus.relock_req = 1'b0;
        bring_up(c + 4, 0, 0, 1);

        // Relock in RUN with pll_locked held high: WAIT_LOCK exits on its first cycle.
        c = cyc;
        push(c + 1, vec(1, 1, 0, 0, 0, lol_m));
        bus.relock_req = 1'b1;
        wait_to(c + 1);
        bus.relock_req = 1'b0;
        push(c + 5,  vec(0, 1, 0, 0, 0, lol_m));
        push(c + 14, vec(0, 0, 1, 0, 0, lol_m));
        wait_to(c + 14);

        // Asynchronous reset in RELEASE (retries=1) clears outputs before any clock edge.
        c = cyc;
        push(c + 1, vec(1, 1, 0, 0, 0, lol_m));
        bus.relock_req = 1'b1;
        bus.pll_locked = 1'b0;
        wait_to(c + 1);
        bus.relock_req = 1'b0;
        bring_up(c + 1, 1, 0, 0);
        s = c + 25;
        wait_to(s + 15);
        push(s + 16, vec(1, 1, 0, 0, 0, 0));
        #2 rst = 1'b1;
        #1 check("async_reset", cyc, sample(), s + 15, vec(1, 1, 0, 0, 0, 0));
        lol_m = 0;
        bus.pll_locked = 1'b0;
        wait_to(s + 20);
        rst = 1'b0;
        bring_up(s + 20, 0, 0, 1);

        wait_to(cyc + 5);
        while (q.size() > 0) begin
            e = q.pop_front();
            total++;
            $display("FAIL missing_change: got no change, want cyc=%0d out=%h", e.cyc, e.v);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
